delay_scheduler: RTL
====================

DELAY_SCHEDULER -- requirements
Module: delay_scheduler

Interface
REQ-001 The block SHALL have parameter CHANNELS, default 8, giving the number of filtered inputs (2..64).
REQ-002 The block SHALL have parameter CNT_BITS, default 16, giving the width of each channel hold counter.
REQ-003 The block SHALL have parameter RISING, default 1, where 1 means the rising edge is delayed and 0 means it passes on the first service.
REQ-004 The block SHALL have parameter FALLING, default 0, with the same meaning for the falling edge.
REQ-005 Port clk, input, 1 bit: the single clock; all logic SHALL be clocked on the rising edge of clk.
REQ-006 Port rst, input, 1 bit: reset; it SHALL be synchronous and active-high.
REQ-007 Port enable, input, 1 bit: slot advance and servicing run only while it is high.
REQ-008 Port delay_set, input, CNT_BITS bits: hold threshold in services.
REQ-009 Port din, input, CHANNELS bits: raw inputs.
REQ-010 Port dout, output, CHANNELS bits: filtered outputs.
REQ-011 Port slot, output, clog2(CHANNELS) bits: index of the channel serviced this cycle.
REQ-012 Port sweep, output, 1 bit: single-cycle pulse when the last channel is serviced.

Function
REQ-013 One shared compare/increment datapath SHALL service exactly one channel per enabled cycle, round-robin 0..CHANNELS-1, then wrap to 0.
REQ-014 Per-channel counters SHALL be held in an array of CHANNELS x CNT_BITS registers; only the serviced entry SHALL change in a cycle.
REQ-015 The active threshold SHALL be a register loaded from delay_set only when slot==0 and enable==1, so a sweep never mixes thresholds.
REQ-016 Service rule, case dout=0, din=0: the counter SHALL be set to 0.
REQ-017 Service rule, case dout=0, din=1, RISING=0: the counter SHALL be set to the threshold and dout SHALL be set to 1.
REQ-018 Service rule, case dout=0, din=1, RISING=1: if counter>=threshold then dout SHALL be set to 1, else the counter SHALL increment.
REQ-019 Service rule, case dout=1, din=1: the counter SHALL be set to the threshold.
REQ-020 Service rule, case dout=1, din=0, FALLING=0: the counter SHALL be set to 0 and dout SHALL be set to 0.
REQ-021 Service rule, case dout=1, din=0, FALLING=1: if counter>0 the counter SHALL decrement, else dout SHALL be set to 0.
REQ-022 The counter SHALL saturate: it never wraps at all-ones or at 0.
REQ-023 A threshold of 0 SHALL make a delayed edge pass on its first service.
REQ-024 The dout bit of the serviced channel SHALL update in the cycle after its service; other bits SHALL hold.
REQ-025 With enable low, slot, the counters and dout SHALL hold, and sweep SHALL be 0.
REQ-026 sweep SHALL be 1 in exactly the cycle where slot==CHANNELS-1 and enable==1.

Reset
REQ-027 While rst is high: slot=0, every counter=0, dout=0, sweep=0, and the threshold register=delay_set.
REQ-028 Reset asserted mid-sweep SHALL abandon the sweep; servicing SHALL restart at slot 0 on the first enabled cycle after release.

Configuration
REQ-029 With macro DELAY_SCHEDULER_SYNC_EN defined, din SHALL pass through a two-flop synchronizer per bit (reset to 0) before servicing, adding 2 cycles of latency.
REQ-030 Without DELAY_SCHEDULER_SYNC_EN, din SHALL be sampled directly in the service cycle.

Structure
REQ-031 Package delay_scheduler_pkg SHALL hold the service-case enumeration (IDLE_LOW, RISE_WAIT, HOLD_HIGH, FALL_WAIT) and the slot-width function.
REQ-032 The per-channel rule SHALL be a combinational sub-module, delay_sched_rule, taking (din, dout, cnt, threshold) and returning (next_cnt, next_dout), instantiated once.

Verification (CHANNELS=4, delay_set=3, RISING=1, FALLING=0, no sync)
REQ-033 Scenario rise: din[2] held at 1 from the first cycle after reset -> dout[2] rises after the 4th service of channel 2, and no other dout bit changes.
REQ-034 Scenario glitch: din[1] high for 2 services, then low -> dout[1] stays 0 and counter[1] returns to 0.
REQ-035 Scenario fall: dout[0]=1, then din[0] goes to 0 -> dout[0] clears in the cycle after the next service of channel 0.
REQ-036 Scenario enable low: enable=0 for 10 cycles mid-sweep -> slot, dout and the counters are frozen, and sweep stays 0.
REQ-037 Scenario threshold change: delay_set changed from 3 to 1 at slot 2 -> the old threshold applies until the next slot 0.
REQ-038 Scenario reset: rst pulsed while counter[3]=2 -> all counters=0, dout=0, and the next service is slot 0.

Source files
------------

// File: rtl/delay_scheduler_pkg.sv
// delay_scheduler_pkg
//   Shared types and helpers for the delay_scheduler block.
//   - svc_case_e : which of the four service cases a channel is in,
//                  encoded directly as {dout, din} so it can be cast
//                  straight from those two bits.
//   - slot_width : width of the slot index for a given channel count
//                  (never less than 1 bit).
package delay_scheduler_pkg;

  typedef enum logic [1:0] {
    IDLE_LOW  = 2'b00,  // output low, input low
    RISE_WAIT = 2'b01,  // output low, input high: qualifying a rising edge
    FALL_WAIT = 2'b10,  // output high, input low: qualifying a falling edge
    HOLD_HIGH = 2'b11   // output high, input high
  } svc_case_e;

  function automatic int slot_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/delay_sched_rule.sv
// delay_sched_rule
//   Combinational per-channel service rule shared by every channel of the
//   scheduler. Given the channel's raw input, current filtered output,
//   hold counter and the active threshold, it produces the counter and
//   output values to write back.
//   Parameters: CNT_BITS (counter width), RISING / FALLING (1 = that edge
//   must be held for the threshold, 0 = it passes on the first service).
//   Ports:
//     din, dout        - raw input and current filtered output of the channel
//     cnt, threshold   - current hold counter and active threshold
//     next_cnt         - counter value to store
//     next_dout        - output value to store
module delay_sched_rule
  import delay_scheduler_pkg::*;
#(
  parameter int CNT_BITS = 16,
  parameter int RISING   = 1,
  parameter int FALLING  = 0
) (
  input  logic                din,
  input  logic                dout,
  input  logic [CNT_BITS-1:0] cnt,
  input  logic [CNT_BITS-1:0] threshold,
  output logic [CNT_BITS-1:0] next_cnt,
  output logic                next_dout
);

  svc_case_e svc;
  assign svc = svc_case_e'({dout, din});

  always_comb begin
    next_cnt  = cnt;
    next_dout = dout;
    case (svc)
      IDLE_LOW: next_cnt = '0;
      RISE_WAIT: begin
        if (RISING == 0) begin
          next_cnt  = threshold;
          next_dout = 1'b1;
        end else if (cnt >= threshold) begin
          next_dout = 1'b1;
        end else if (cnt != '1) begin
          // Saturating increment; an all-ones counter already meets any threshold.
          next_cnt = cnt + CNT_BITS'(1);
        end
      end
      HOLD_HIGH: next_cnt = threshold;
      FALL_WAIT: begin
        if (FALLING == 0) begin
          next_cnt  = '0;
          next_dout = 1'b0;
        end else if (cnt != '0) begin
          next_cnt = cnt - CNT_BITS'(1);
        end else begin
          next_dout = 1'b0;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/delay_scheduler.sv
// delay_scheduler
//   Time-multiplexed debounce/delay filter. One shared rule datapath
//   services one channel per enabled cycle in round-robin order; each
//   channel keeps its own hold counter and filtered output bit.
//   Optional build macro: DELAY_SCHEDULER_SYNC_EN adds a two-flop
//   synchronizer on every din bit (2 cycles of extra latency).
//   Ports:
//     clk        - clock, rising edge
//     rst        - synchronous active-high reset
//     enable     - advances the slot and services while high
//     delay_set  - hold threshold in services (captured at slot 0)
//     din        - raw inputs, one per channel
//     dout       - filtered outputs
//     slot       - channel serviced this cycle
//     sweep      - pulses while the last channel is serviced
module delay_scheduler
  import delay_scheduler_pkg::*;
#(
  parameter int CHANNELS = 8,
  parameter int CNT_BITS = 16,
  parameter int RISING   = 1,
  parameter int FALLING  = 0
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              enable,
  input  logic [CNT_BITS-1:0]               delay_set,
  input  logic [CHANNELS-1:0]               din,
  output logic [CHANNELS-1:0]               dout,
  output logic [slot_width(CHANNELS)-1:0]   slot,
  output logic                              sweep
);

  localparam int SLOT_W = slot_width(CHANNELS);
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(CHANNELS - 1);

  logic [SLOT_W-1:0]   slot_reg;
  logic [CHANNELS-1:0] dout_reg;
  logic [CNT_BITS-1:0] cnt_mem [CHANNELS];
  logic [CNT_BITS-1:0] thr_reg;
  logic [CNT_BITS-1:0] thr_active;
  logic [CHANNELS-1:0] din_svc;
  logic [CNT_BITS-1:0] cnt_next;
  logic                dout_next;

`ifdef DELAY_SCHEDULER_SYNC_EN
  logic [CHANNELS-1:0] sync1_reg;
  logic [CHANNELS-1:0] sync2_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_reg <= '0;
      sync2_reg <= '0;
    end else begin
      sync1_reg <= din;
      sync2_reg <= sync1_reg;
    end
  end

  assign din_svc = sync2_reg;
`else
  assign din_svc = din;
`endif

  // The slot-0 service already uses the incoming delay_set, so every
  // channel of one sweep sees the same threshold.
  always_ff @(posedge clk) begin
    if (rst) begin
      thr_reg <= delay_set;
    end else if (enable && slot_reg == '0) begin
      thr_reg <= delay_set;
    end
  end

  assign thr_active = (slot_reg == '0) ? delay_set : thr_reg;

  delay_sched_rule #(
    .CNT_BITS (CNT_BITS),
    .RISING   (RISING),
    .FALLING  (FALLING)
  ) u_rule (
    .din       (din_svc[slot_reg]),
    .dout      (dout_reg[slot_reg]),
    .cnt       (cnt_mem[slot_reg]),
    .threshold (thr_active),
    .next_cnt  (cnt_next),
    .next_dout (dout_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_reg <= '0;
      dout_reg <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        cnt_mem[i] <= '0;
      end
    end else if (enable) begin
      cnt_mem[slot_reg]  <= cnt_next;
      dout_reg[slot_reg] <= dout_next;
      slot_reg           <= (slot_reg == LAST_SLOT) ? '0 : slot_reg + SLOT_W'(1);
    end
  end

  assign dout  = dout_reg;
  assign slot  = slot_reg;
  assign sweep = enable && !rst && (slot_reg == LAST_SLOT);

endmodule
